config_loader: RTL
==================

Name: config_loader

Overview:
- Configuration initiator for the tile array: accepts a byte-wide bitstream, parses framed configuration records and drives the shared config bus (config_en, config_addr, config_data) consumed by every tile.
- One record configures exactly one tile address.
- Sits between the external programming interface and the tile grid.
- It is the only driver of the config bus.

Parameters:
- DATA_BITS, 88: width of config_data, equal to the full tile config word (switch + two connect + output select).
- SYNC, 8'hA5: frame start byte.
- NBYTES, derived as ceil(DATA_BITS/8) = 11: data bytes per frame. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  bitstream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready at a clk edge.
- err_clr  in  1  clears csum_err.
- config_en  out  1  one-cycle write strobe to tiles.
- config_addr  out  6  target tile address.
- config_data  out  [0:DATA_BITS-1]  tile config word; bit 0 is the first bit of the stream.
- busy  out  1  frame in progress.
- csum_err  out  1  sticky checksum failure flag.
- frame_count  out  16  number of successful writes.

Behaviour:
- Reset: synchronous and active-high.
  - State returns to HUNT.
  - config_en=0, config_addr=0, config_data=0, csum_err=0, frame_count=0.
  - in_ready=0 while rst is high.
- States: HUNT, ADDR, DATA, CSUM, WRITE.
  - in_ready is a combinational decode: 1 in HUNT, ADDR, DATA and CSUM, and 0 in WRITE or during rst.
  - busy=1 in every state except HUNT.
- HUNT:
  - Accepted byte == SYNC: go to ADDR and clear the running checksum.
  - Any other byte: discard it and stay in HUNT.
- ADDR:
  - Capture in_data[5:0] as the pending address.
  - Checksum ^= full byte. Bits [7:6] are ignored for addressing but included in the checksum.
  - Clear the byte counter, then go to DATA.
- DATA:
  - Each accepted byte shifts into the pending word. Byte k maps MSB-first onto config_data[8k : 8k+7].
  - Bits beyond DATA_BITS-1 in the last byte are discarded but checksummed.
  - After NBYTES bytes, go to CSUM.
- CSUM: accepted byte compared with the running XOR of the address byte and all data bytes.
  - Match: go to WRITE.
  - Mismatch: set csum_err, return to HUNT, and leave config_* unchanged.
- WRITE, one cycle only:
  - config_en=1.
  - config_addr and config_data are loaded from the pending registers on the same edge config_en rises, so they are valid throughout the strobe cycle.
  - frame_count increments, wrapping from 16'hFFFF to 0.
  - Next state is HUNT.
- Latency: config_en is high in the cycle immediately after the clk edge that accepts the checksum byte.
- Throughput: one bubble cycle per frame (WRITE). Minimum frame is 14 cycles plus the bubble.
- Bus holding:
  - config_addr and config_data hold their last written values between writes.
  - They never change while config_en=0 except on reset.
- in_valid gaps: allowed at any point and stall the FSM in place. There is no timeout.
- SYNC inside a frame: treated as ordinary data. There is no resync mid-frame.
- err_clr:
  - Clears csum_err on the next edge.
  - If err_clr and a new mismatch occur on the same edge, csum_err=1 (set wins).
- Reset mid-frame: the partial frame is dropped, no config_en is issued, and the next frame must start with SYNC.
- rst and WRITE on the same edge: rst wins; config_en stays 0.

Test Plan:
- Good frame:
  - Stimulus: A5, 05, 12, ten 00 bytes, checksum 17.
  - Response: exactly one config_en pulse, one cycle after checksum acceptance; config_addr=5; config_data[0:7]=8'h12 (bits 3 and 6 set), all other bits 0; frame_count=1; csum_err=0.
- Bad checksum:
  - Stimulus: same frame with checksum 16.
  - Response: no config_en; csum_err=1; config_addr and config_data keep their prior values; frame_count unchanged.
  - Then pulse err_clr: csum_err=0 next cycle.
- Junk before sync:
  - Stimulus: 00, FF, 5A, then the good frame.
  - Response: junk is ignored, busy stays 0 until A5, then a single write to address 5.
- Back-to-back frames with random in_valid gaps and an address byte of C3:
  - Response: config_addr=3 (upper bits dropped); checksum includes C3.
  - in_ready=0 for exactly one cycle per frame; frame_count=2.
- Reset mid-frame:
  - Stimulus: assert rst after the 4th data byte, then send a complete good frame.
  - Response: no write from the partial frame; all outputs at reset values one cycle after rst; exactly one write afterwards.
- Data byte equal to SYNC:
  - Stimulus: a frame with the data byte A5 inside it.
  - Response: the byte is stored as data and the frame completes normally.
- frame_count wrap:
  - Stimulus: preload via 65536 frames, or force the counter to FFFF, then send a good frame.
  - Response: frame_count=0 after the write.

Source files
------------

// File: rtl/config_loader.sv
// Configuration loader: parses SYNC-framed records from a byte stream
// (sync, address, NBYTES data bytes, XOR checksum) and drives the shared
// tile configuration bus with a one-cycle write strobe per good record.
module config_loader #(
  parameter int unsigned DATA_BITS = 88,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 err_clr,
  output logic                 config_en,
  output logic [5:0]           config_addr,
  output logic [0:DATA_BITS-1] config_data,
  output logic                 busy,
  output logic                 csum_err,
  output logic [15:0]          frame_count
);

  localparam int unsigned NBYTES = (DATA_BITS + 7) / 8;
  localparam int unsigned PendW  = NBYTES * 8;
  localparam int unsigned CntW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {StHunt, StAddr, StData, StCsum, StWrite} state_e;

  state_e state_q, state_d;

  logic [7:0]           csum_q, csum_d;
  logic [5:0]           addr_pend_q, addr_pend_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [PendW-1:0]     pend_q, pend_d;
  logic [5:0]           cfg_addr_q, cfg_addr_d;
  logic [0:DATA_BITS-1] cfg_data_q, cfg_data_d;
  logic [0:DATA_BITS-1] pend_word;
  logic [15:0]          count_q, count_d;
  logic                 err_q, err_d;

  logic accept;
  logic last_data;
  logic csum_ok;
  logic csum_bad;

  assign accept    = in_valid & in_ready;
  assign last_data = (cnt_q == CntW'(NBYTES - 1));
  assign csum_ok   = (state_q == StCsum) && accept && (in_data == csum_q);
  assign csum_bad  = (state_q == StCsum) && accept && (in_data != csum_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in_valid gaps simply hold the current state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHunt:  if (accept && (in_data == SYNC)) state_d = StAddr;
      StAddr:  if (accept) state_d = StData;
      StData:  if (accept && last_data) state_d = StCsum;
      StCsum:  if (accept) state_d = csum_ok ? StWrite : StHunt;
      StWrite: state_d = StHunt;
      default: state_d = StHunt;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready  = !rst && (state_q != StWrite);
    busy      = (state_q != StHunt);
    config_en = (state_q == StWrite);
  end

  // Stream byte k sits at pend bits [PendW-1-8k -: 8]; its MSB becomes word bit 8k.
  always_comb begin
    pend_word = '0;
    for (int i = 0; i < int'(DATA_BITS); i++) begin
      pend_word[i] = pend_q[int'(PendW) - 1 - i];
    end
  end

  // Datapath next-state: checksum, pending record, bus registers and status.
  always_comb begin
    csum_d      = csum_q;
    addr_pend_d = addr_pend_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    count_d     = count_q;
    err_d       = err_q;

    if (accept) begin
      unique case (state_q)
        StHunt: if (in_data == SYNC) csum_d = '0;
        StAddr: begin
          addr_pend_d = in_data[5:0];
          csum_d      = csum_q ^ in_data;
          cnt_d       = '0;
        end
        StData: begin
          pend_d = (pend_q << 8) | PendW'(in_data);
          csum_d = csum_q ^ in_data;
          cnt_d  = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end

    // Bus is loaded on the edge that enters StWrite so it is valid with the strobe.
    if (csum_ok) begin
      cfg_addr_d = addr_pend_q;
      cfg_data_d = pend_word;
      count_d    = count_q + 16'd1;
    end

    // A new mismatch wins over a simultaneous clear.
    if (csum_bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q      <= '0;
      addr_pend_q <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      csum_q      <= csum_d;
      addr_pend_q <= addr_pend_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign config_addr = cfg_addr_q;
  assign config_data = cfg_data_q;
  assign frame_count = count_q;
  assign csum_err    = err_q;

endmodule
